// File: rtl/map_arb_pkg.sv
// Shared types and constants for the map BRAM read-port arbiter.
// Tags identify which requester owns a read that is in flight.
package map_arb_pkg;

    typedef logic [1:0] tag_t;

    localparam tag_t TAG_NONE = 2'd0;
    localparam tag_t TAG_VID  = 2'd1;
    localparam tag_t TAG_P1   = 2'd2;
    localparam tag_t TAG_P2   = 2'd3;

    localparam int unsigned DEF_ADDR_W = 17;
    localparam int unsigned DEF_DATA_W = 12;

    // First word of the map image inside the BRAM.
    localparam int unsigned MAP_BASE_ADDR = 90001;

endpackage

// File: rtl/rd_tag_pipe.sv
// Tag shift register that tracks reads in flight through the BRAM.
// The last stage lines up with the cycle bram_dout carries that read.
module rd_tag_pipe
    import map_arb_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  tag_t issue_tag,
    output tag_t ret_tag
);

    tag_t stage_q [RD_LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                stage_q[i] <= TAG_NONE;
            end
        end else begin
            stage_q[0] <= issue_tag;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign ret_tag = stage_q[RD_LAT-1];

endmodule

// File: rtl/map_port_arbiter.sv
// Shares the map BRAM read port: video has absolute priority, the two physics
// probes fill free slots round-robin, and read data is steered back by tag.
module map_port_arbiter
    import map_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned STARVE_LIMIT = 800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_data,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    input  logic              p2_req,
    input  logic [ADDR_W-1:0] p2_addr,
    output logic              p2_gnt,
    output logic              p2_rvalid,
    output logic [DATA_W-1:0] p2_rdata,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    input  logic              starve_clr,
    output logic [1:0]        starve
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic vid_win, p1_win, p2_win;
    logic rr_q, rr_d;
    tag_t issue_tag, ret_tag;
    logic [DATA_W-1:0] p1_rdata_q, p2_rdata_q;
    logic [1:0] req_v, gnt_v, set_v;
    logic [1:0][CNT_W-1:0] wait_q, wait_d;
    logic [1:0] starve_q, starve_d;

    // rr_q = 0 favours P1, 1 favours P2; reset gates every grant.
    always_comb begin
        vid_win = rst & vid_req;
        p1_win  = rst & ~vid_req & p1_req & (~p2_req | ~rr_q);
        p2_win  = rst & ~vid_req & p2_req & (~p1_req | rr_q);
    end

    always_comb begin
        bram_en   = vid_win | p1_win | p2_win;
        bram_addr = '0;
        issue_tag = TAG_NONE;
        if (vid_win) begin
            bram_addr = vid_addr;
            issue_tag = TAG_VID;
        end else if (p1_win) begin
            bram_addr = p1_addr;
            issue_tag = TAG_P1;
        end else if (p2_win) begin
            bram_addr = p2_addr;
            issue_tag = TAG_P2;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (p1_win) begin
            rr_d = 1'b1;
        end else if (p2_win) begin
            rr_d = 1'b0;
        end
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .issue_tag (issue_tag),
        .ret_tag   (ret_tag)
    );

    assign p1_gnt     = p1_win;
    assign p2_gnt     = p2_win;
    assign vid_rvalid = (ret_tag == TAG_VID);
    assign vid_data   = bram_dout;
    assign p1_rvalid  = (ret_tag == TAG_P1);
    assign p2_rvalid  = (ret_tag == TAG_P2);
    // Probe data shows in its rvalid cycle, then the capture register holds it.
    assign p1_rdata   = p1_rvalid ? bram_dout : p1_rdata_q;
    assign p2_rdata   = p2_rvalid ? bram_dout : p2_rdata_q;

    assign req_v = {p2_req, p1_req};
    assign gnt_v = {p2_win, p1_win};

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            wait_d[i] = '0;
            set_v[i]  = 1'b0;
            if (req_v[i] && !gnt_v[i]) begin
                wait_d[i] = (wait_q[i] == CNT_MAX) ? wait_q[i] : wait_q[i] + 1'b1;
                set_v[i]  = (wait_d[i] == CNT_MAX);
            end
        end
        // A new set outranks a simultaneous clear.
        starve_d = (starve_clr ? 2'b00 : starve_q) | set_v;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q       <= 1'b0;
            p1_rdata_q <= '0;
            p2_rdata_q <= '0;
            wait_q     <= '0;
            starve_q   <= 2'b00;
        end else begin
            rr_q     <= rr_d;
            wait_q   <= wait_d;
            starve_q <= starve_d;
            if (p1_rvalid) begin
                p1_rdata_q <= bram_dout;
            end
            if (p2_rvalid) begin
                p2_rdata_q <= bram_dout;
            end
        end
    end

    assign starve = starve_q;

endmodule

// File: tb/tb_map_port_arbiter.sv
// Directed bench: drivers push expected read responses into per-port queues,
// a monitor pops and compares them whenever the DUT signals a response.
module tb_map_port_arbiter;
    import map_arb_pkg::*;

    localparam int unsigned RD_LAT = 2;
    localparam int unsigned LIMIT  = 8;
    localparam int G_NONE = 0;
    localparam int G_VID  = 1;
    localparam int G_P1   = 2;
    localparam int G_P2   = 3;

    typedef struct {
        logic [11:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        vid_req, p1_req, p2_req, starve_clr;
    logic [16:0] vid_addr, p1_addr, p2_addr;
    logic        vid_rvalid, p1_gnt, p1_rvalid, p2_gnt, p2_rvalid, bram_en;
    logic [11:0] vid_data, p1_rdata, p2_rdata, bram_dout;
    logic [16:0] bram_addr;
    logic [1:0]  starve;

    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t q_vid[$];
    exp_t q_p1[$];
    exp_t q_p2[$];
    logic [11:0] last [3];
    string pn [3] = '{"vid", "p1", "p2"};
    logic [16:0] pa [RD_LAT];

    map_port_arbiter #(
        .ADDR_W       (17),
        .DATA_W       (12),
        .RD_LAT       (RD_LAT),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_rvalid (vid_rvalid),
        .vid_data   (vid_data),
        .p1_req     (p1_req),
        .p1_addr    (p1_addr),
        .p1_gnt     (p1_gnt),
        .p1_rvalid  (p1_rvalid),
        .p1_rdata   (p1_rdata),
        .p2_req     (p2_req),
        .p2_addr    (p2_addr),
        .p2_gnt     (p2_gnt),
        .p2_rvalid  (p2_rvalid),
        .p2_rdata   (p2_rdata),
        .bram_en    (bram_en),
        .bram_addr  (bram_addr),
        .bram_dout  (bram_dout),
        .starve_clr (starve_clr),
        .starve     (starve)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] mem_f(input logic [16:0] a);
        return a[11:0] ^ {a[16:12], 7'h2B};
    endfunction

    // BRAM model with RD_LAT cycles of read latency.
    always @(posedge clk) begin
        if (bram_en) pa[0] <= bram_addr;
        for (int i = 1; i < int'(RD_LAT); i++) pa[i] <= pa[i-1];
    end
    assign bram_dout = mem_f(pa[RD_LAT-1]);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic rst_checks();
        check("rst bram_en", 32'(bram_en), 32'd0);
        check("rst bram_addr", 32'(bram_addr), 32'd0);
        check("rst p1_gnt", 32'(p1_gnt), 32'd0);
        check("rst p2_gnt", 32'(p2_gnt), 32'd0);
        check("rst vid_rvalid", 32'(vid_rvalid), 32'd0);
        check("rst p1_rvalid", 32'(p1_rvalid), 32'd0);
        check("rst p2_rvalid", 32'(p2_rvalid), 32'd0);
        check("rst p1_rdata", 32'(p1_rdata), 32'd0);
        check("rst p2_rdata", 32'(p2_rdata), 32'd0);
        check("rst starve", 32'(starve), 32'd0);
    endtask

    task automatic drive_idle();
        vid_req = 1'b0; vid_addr = '0;
        p1_req = 1'b0;  p1_addr = '0;
        p2_req = 1'b0;  p2_addr = '0;
        starve_clr = 1'b0;
    endtask

    // One cycle of stimulus with the hand-chosen expected grant and starve flags.
    task automatic vec(input logic vr, input int va, input logic r1, input int a1,
                       input logic r2, input int a2, input logic clr, input int eg,
                       input logic [1:0] es);
        logic [16:0] ea;
        exp_t e;
        @(posedge clk); #1;
        vid_req = vr; vid_addr = 17'(va);
        p1_req = r1;  p1_addr = 17'(a1);
        p2_req = r2;  p2_addr = 17'(a2);
        starve_clr = clr;
        @(negedge clk);
        case (eg)
            G_VID:   ea = 17'(va);
            G_P1:    ea = 17'(a1);
            G_P2:    ea = 17'(a2);
            default: ea = '0;
        endcase
        check("bram_en", 32'(bram_en), 32'(eg != G_NONE));
        check("bram_addr", 32'(bram_addr), 32'(ea));
        check("p1_gnt", 32'(p1_gnt), 32'(eg == G_P1));
        check("p2_gnt", 32'(p2_gnt), 32'(eg == G_P2));
        check("starve", 32'(starve), 32'(es));
        e.data = mem_f(ea);
        e.cyc  = cyc + int'(RD_LAT);
        if (eg == G_VID) q_vid.push_back(e);
        if (eg == G_P1) q_p1.push_back(e);
        if (eg == G_P2) q_p2.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) vec(0, 0, 0, 0, 0, 0, 0, G_NONE, 2'b00);
    endtask

    task automatic mon(input int p, input logic rv, input logic [11:0] d);
        exp_t e;
        bit due;
        due = 0;
        case (p)
            0: if (q_vid.size() != 0 && q_vid[0].cyc == cyc) begin e = q_vid.pop_front(); due = 1; end
            1: if (q_p1.size() != 0 && q_p1[0].cyc == cyc) begin e = q_p1.pop_front(); due = 1; end
            default: if (q_p2.size() != 0 && q_p2[0].cyc == cyc) begin e = q_p2.pop_front(); due = 1; end
        endcase
        if (due) begin
            check({pn[p], " rvalid"}, 32'(rv), 32'd1);
            check({pn[p], " data"}, 32'(d), 32'(e.data));
            last[p] = e.data;
        end else begin
            check({pn[p], " idle rvalid"}, 32'(rv), 32'd0);
            if (p != 0) check({pn[p], " held rdata"}, 32'(d), 32'(last[p]));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk); #2;
            mon(0, vid_rvalid, vid_data);
            mon(1, p1_rvalid, p1_rdata);
            mon(2, p2_rvalid, p2_rdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 3; i++) last[i] = '0;
        rst = 1'b0;
        drive_idle();
        vid_req = 1'b1; p1_req = 1'b1; p2_req = 1'b1;
        vid_addr = 17'(MAP_BASE_ADDR); p1_addr = 17'd7; p2_addr = 17'd9;
        @(negedge clk);
        rst_checks();
        @(posedge clk); #1;
        drive_idle();
        rst = 1'b1;

        // Video stream owns the port; data follows RD_LAT later.
        for (int i = 0; i < 10; i++) vec(1, int'(MAP_BASE_ADDR) + i, 0, 0, 0, 0, 0, G_VID, 2'b00);

        // Both probes pending: round-robin starting at P1.
        vec(0, 0, 1, 1000, 1, 2000, 0, G_P1, 2'b00);
        vec(0, 0, 1, 1000, 1, 2000, 0, G_P2, 2'b00);
        vec(0, 0, 1, 1001, 1, 2000, 0, G_P1, 2'b00);
        vec(0, 0, 1, 1001, 1, 2001, 0, G_P2, 2'b00);
        idle(1);

        // P1 blocked by video for 10 cycles: starve[0] rises after the 8th wait.
        for (int i = 0; i < 10; i++)
            vec(1, 90011 + i, 1, 95000, 0, 0, 0, G_VID, (i >= int'(LIMIT)) ? 2'b01 : 2'b00);
        vec(0, 0, 1, 95000, 0, 0, 0, G_P1, 2'b01);
        vec(0, 0, 0, 0, 0, 0, 1, G_NONE, 2'b01);

        // P2 starves; clear while still waiting loses to set, clear after grant wins.
        for (int i = 0; i < int'(LIMIT); i++) vec(1, 90021 + i, 0, 0, 1, 3000, 0, G_VID, 2'b00);
        vec(1, 90029, 0, 0, 1, 3000, 1, G_VID, 2'b10);
        vec(0, 0, 0, 0, 1, 3000, 0, G_P2, 2'b10);
        vec(0, 0, 0, 0, 0, 0, 1, G_NONE, 2'b10);
        idle(1);

        // Reset with a P1 read in flight: the response must never appear.
        vec(0, 0, 1, 4000, 0, 0, 0, G_P1, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;
        vid_req = 1'b1; p1_req = 1'b1; p2_req = 1'b1;
        q_vid.delete(); q_p1.delete(); q_p2.delete();
        for (int i = 0; i < 3; i++) last[i] = '0;
        @(negedge clk);
        rst_checks();
        @(negedge clk);
        rst_checks();
        @(posedge clk); #1;
        drive_idle();
        rst = 1'b1;
        vec(0, 0, 1, 4001, 1, 4002, 0, G_P1, 2'b00);
        vec(0, 0, 0, 0, 1, 4002, 0, G_P2, 2'b00);
        idle(2);

        // Interleaved video and probe grants; each response to its own port.
        vec(1, 90030, 1, 5001, 1, 6001, 0, G_VID, 2'b00);
        vec(0, 0, 1, 5001, 1, 6001, 0, G_P1, 2'b00);
        vec(1, 90031, 1, 5002, 1, 6001, 0, G_VID, 2'b00);
        vec(0, 0, 1, 5002, 1, 6001, 0, G_P2, 2'b00);
        vec(1, 90032, 1, 5002, 1, 6002, 0, G_VID, 2'b00);
        vec(0, 0, 1, 5002, 1, 6002, 0, G_P1, 2'b00);
        vec(0, 0, 0, 0, 1, 6002, 0, G_P2, 2'b00);
        idle(4);

        @(negedge clk); #3;
        check("vid responses drained", 32'(q_vid.size()), 32'd0);
        check("p1 responses drained", 32'(q_p1.size()), 32'd0);
        check("p2 responses drained", 32'(q_p2.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
